// File: rtl/cic_comp_pkg.sv
// Shared types and constant helpers for the CIC droop-compensation FIR.
package cic_comp_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int coef_frac(input int coef_w);
    return coef_w - 2;
  endfunction

  function automatic int coef_unity(input int coef_w);
    return 1 << coef_frac(coef_w);
  endfunction

  // Clamp a sign-extended value to the range of a w-bit signed word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Registered multiplier feeding an accumulator; two-cycle pipe from operands to acc_o.
module cic_comp_mac #(
  parameter int A_W   = 16,
  parameter int B_W   = 18,
  parameter int ACC_W = 38
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  localparam int PW = A_W + B_W;

  logic                    vld_p1;
  logic                    clr_p1;
  logic signed [PW-1:0]    prod_p1;
  logic signed [ACC_W-1:0] prod_ext_p1;
  logic signed [ACC_W-1:0] acc_p2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1 <= 1'b0;
      clr_p1 <= 1'b0;
    end else begin
      vld_p1 <= en_i;
      clr_p1 <= clr_i;
    end
  end

  // p0 -> p1: product register
  always_ff @(posedge clk_i) begin
    if (en_i) prod_p1 <= PW'(a_i) * PW'(b_i);
  end

  assign prod_ext_p1 = ACC_W'(prod_p1);

  // p1 -> p2: accumulator, restarted by the tap-0 product
  always_ff @(posedge clk_i) begin
    if (vld_p1) acc_p2 <= clr_p1 ? prod_ext_p1 : acc_p2 + prod_ext_p1;
  end

  assign acc_o = acc_p2;

endmodule

// File: rtl/cic_comp_fir.sv
// Serial-MAC CIC droop-compensation FIR with runtime-loadable coefficients.
// Define CIC_COMP_ROUND_EN for round-half-up output scaling; otherwise the output is floored.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = 16,
  parameter int COEF_WIDTH    = 18,
  parameter int NTAPS         = 16,
  localparam int AW = clog2(NTAPS)
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic signed [DATAIN_WIDTH-1:0]  data_i,
  input  logic                            val_i,
  input  logic                            coef_we_i,
  input  logic [AW-1:0]                   coef_addr_i,
  input  logic signed [COEF_WIDTH-1:0]    coef_data_i,
  output logic signed [DATAOUT_WIDTH-1:0] data_o,
  output logic                            val_o,
  output logic                            busy_o,
  output logic                            ovf_o
);

  localparam int COEF_FRAC = coef_frac(COEF_WIDTH);
  localparam int ACC_W     = DATAIN_WIDTH + COEF_WIDTH + AW;
  localparam logic signed [COEF_WIDTH-1:0] UNITY = COEF_WIDTH'(coef_unity(COEF_WIDTH));
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEF_FRAC - 1);

  state_t                         state, state_nxt;
  logic                           accept;
  logic [AW-1:0]                  wr_ptr, base, tap, rd_addr;
  logic                           drain;
  int                             rd_idx;
  logic signed [DATAIN_WIDTH-1:0] hist [NTAPS];
  logic signed [COEF_WIDTH-1:0]   coef [NTAPS];
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        q;
  logic signed [63:0]             q_sat;

  function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
`ifdef CIC_COMP_ROUND_EN
    t = a + RND;
`else
    t = a;
`endif
    return t >>> COEF_FRAC;
  endfunction

  assign busy_o = (state == MAC) || (state == DRAIN);
  assign val_o  = (state == OUT);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:  if (val_i) begin state_nxt = MAC; accept = 1'b1; end
      MAC:   if (tap == AW'(NTAPS - 1)) state_nxt = DRAIN;
      DRAIN: if (drain) state_nxt = OUT;
      OUT: begin
        accept    = val_i;
        state_nxt = val_i ? MAC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      wr_ptr <= '0;
      base   <= '0;
      tap    <= '0;
      drain  <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      drain <= (state == DRAIN);
      if (accept) begin
        base   <= wr_ptr;
        wr_ptr <= (wr_ptr == AW'(NTAPS - 1)) ? '0 : wr_ptr + 1'b1;
        tap    <= '0;
      end else if (state == MAC) begin
        tap <= tap + 1'b1;
      end
      if (val_i && busy_o) ovf_o <= 1'b1;
    end
  end

  // Newest sample sits at base; older taps walk backwards around the ring.
  always_comb begin
    rd_idx = int'(base) - int'(tap);
    if (rd_idx < 0) rd_idx = rd_idx + NTAPS;
    rd_addr = AW'(rd_idx);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NTAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      if (accept) hist[wr_ptr] <= data_i;
      if (coef_we_i && !busy_o && (int'(coef_addr_i) < NTAPS)) coef[coef_addr_i] <= coef_data_i;
    end
  end

  cic_comp_mac #(
    .A_W   (DATAIN_WIDTH),
    .B_W   (COEF_WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (state == MAC),
    .clr_i   ((state == MAC) && (tap == '0)),
    .a_i     (hist[rd_addr]),
    .b_i     (coef[tap]),
    .acc_o   (acc)
  );

  assign q     = scale(acc);
  assign q_sat = saturate(64'(q), DATAOUT_WIDTH);

  // acc is final during the second drain cycle; publish it as the FSM enters OUT
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                   data_o <= '0;
    else if (state == DRAIN && drain) data_o <= DATAOUT_WIDTH'(q_sat);
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir (NTAPS=16, default widths).
module tb_cic_comp_fir;

  localparam int DW = 16;
  localparam int OW = 16;
  localparam int CW = 18;
  localparam int NT = 16;
  localparam int AW = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic signed [DW-1:0] data_i = '0;
  logic                 val_i = 1'b0;
  logic                 coef_we_i = 1'b0;
  logic [AW-1:0]        coef_addr_i = '0;
  logic signed [CW-1:0] coef_data_i = '0;
  logic signed [OW-1:0] data_o;
  logic                 val_o;
  logic                 busy_o;
  logic                 ovf_o;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  cic_comp_fir #(
    .DATAIN_WIDTH  (DW),
    .DATAOUT_WIDTH (OW),
    .COEF_WIDTH    (CW),
    .NTAPS         (NT)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .data_i      (data_i),
    .val_i       (val_i),
    .coef_we_i   (coef_we_i),
    .coef_addr_i (coef_addr_i),
    .coef_data_i (coef_data_i),
    .data_o      (data_o),
    .val_o       (val_o),
    .busy_o      (busy_o),
    .ovf_o       (ovf_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    val_i = 1'b0;
    coef_we_i = 1'b0;
    step();
    step();
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic wr_coef(input int a, input int v);
    coef_we_i   = 1'b1;
    coef_addr_i = AW'(a);
    coef_data_i = CW'(v);
    step();
    coef_we_i = 1'b0;
  endtask

  // Advance until val_o or a cycle budget; lat counts cycles since the accept cycle.
  task automatic wait_val(inout int lat);
    while (val_o !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic send(input logic signed [DW-1:0] x, output int lat);
    data_i = x;
    val_i  = 1'b1;
    step();
    val_i  = 1'b0;
    data_i = '0;
    lat = 1;
    wait_val(lat);
  endtask

  task automatic send_chk(input string tag, input logic signed [DW-1:0] x, input int exp);
    int lat;
    send(x, lat);
    chk({tag, "_lat"}, lat, 19);
    chk(tag, data_o, exp);
  endtask

  initial begin
    int lat, busy_cnt, pulses, first, got;

    // Reset state
    rst_n_i = 1'b0;
    #1;
    chk("rst_data", data_o, 0);
    chk("rst_val", val_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", ovf_o, 0);
    do_reset();

    // 1: pass-through after reset, latency and busy window
    data_i = 16'sd1000;
    val_i  = 1'b1;
    step();
    val_i = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (val_o !== 1'b1 && lat < 60) begin
      if (busy_o) busy_cnt++;
      step();
      lat++;
    end
    chk("pt_lat", lat, 19);
    chk("pt_busy_cycles", busy_cnt, 18);
    chk("pt_busy_at_val", busy_o, 0);
    chk("pt_data", data_o, 1000);
    step();
    chk("pt_val_pulse", val_o, 0);
    chk("pt_hold", data_o, 1000);

    // 2: impulse 2^14 against c[k]=(k+1)*2^12 -> (k+1)*2^26 >> 16 = 1024*(k+1)
    do_reset();
    for (int k = 0; k < NT; k++) wr_coef(k, (k + 1) * 4096);
    send_chk("imp0", 16'sd16384, 1024);
    for (int k = 1; k < NT; k++) send_chk($sformatf("imp%0d", k), 16'sd0, 1024 * (k + 1));
    chk("imp_no_ovf", ovf_o, 0);

    // 3: input during busy is dropped and flagged
    do_reset();
    data_i = 16'sd1000;
    val_i  = 1'b1;
    step();
    val_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("ovf_before", ovf_o, 0);
    data_i = 16'sd7777;
    val_i  = 1'b1;
    step();
    val_i = 1'b0;
    chk("ovf_set", ovf_o, 1);
    pulses = 0;
    first = -1;
    got = 0;
    for (int c = 6; c < 46; c++) begin
      if (val_o) begin
        pulses++;
        if (first < 0) begin
          first = c;
          got = data_o;
        end
      end
      step();
    end
    chk("ovf_pulses", pulses, 1);
    chk("ovf_lat", first, 19);
    chk("ovf_data", got, 1000);
    wr_coef(0, 0);
    wr_coef(1, 65536);
    send_chk("ovf_hist", 16'sd0, 1000);
    chk("ovf_sticky", ovf_o, 1);

    // 4: saturation at both rails
    do_reset();
    for (int k = 1; k < NT; k++) wr_coef(k, 65536);
    send_chk("sat_first", 16'sd32767, 32767);
    for (int i = 1; i < NT - 1; i++) send(16'sd32767, lat);
    send_chk("sat_pos", 16'sd32767, 32767);
    for (int i = 0; i < NT - 1; i++) send(-16'sd32768, lat);
    send_chk("sat_neg", -16'sd32768, -32768);

    // 5: half-gain tap exercises the shift rounding
    do_reset();
    wr_coef(0, 32768);
`ifdef CIC_COMP_ROUND_EN
    send_chk("rnd_pos", 16'sd3, 2);
    send_chk("rnd_neg", -16'sd3, -1);
`else
    send_chk("rnd_pos", 16'sd3, 1);
    send_chk("rnd_neg", -16'sd3, -2);
`endif

    // 6: reset mid-computation, then coefficient lock while busy
    wr_coef(0, 32768);
    data_i = 16'sd1000;
    val_i  = 1'b1;
    step();
    val_i = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst_n_i = 1'b0;
    #1;
    chk("mid_busy", busy_o, 0);
    chk("mid_val", val_o, 0);
    step();
    rst_n_i = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (val_o) pulses++;
      step();
    end
    chk("mid_no_val", pulses, 0);
    chk("mid_data", data_o, 0);
    send_chk("mid_unity", 16'sd1000, 1000);

    data_i = 16'sd200;
    val_i  = 1'b1;
    step();
    val_i = 1'b0;
    step();
    step();
    chk("lock_busy", busy_o, 1);
    wr_coef(0, 0);
    lat = 4;
    wait_val(lat);
    chk("lock_lat", lat, 19);
    chk("lock_data", data_o, 200);
    send_chk("lock_next", 16'sd300, 300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
